// File: rtl/fractal_sync_pkg.sv
// Shared types and widths for the fractal_sync request path.
// A request is the {set, idx, sd} triple carried from the port down to the RF.
package fractal_sync_pkg;

    localparam int unsigned SD_WIDTH      = 2;
    localparam int unsigned REQ_IDX_WIDTH = 1;

    typedef struct packed {
        logic                     set;
        logic [REQ_IDX_WIDTH-1:0] idx;
        logic [SD_WIDTH-1:0]      sd;
    } fractal_sync_req_t;

endpackage

// File: rtl/fractal_sync_req_fifo.sv
// Per-port request FIFO: registered storage, head always visible on `head`.
// Full/empty come from an occupancy count so pointers may wrap freely.
module fractal_sync_req_fifo
    import fractal_sync_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  logic              pop,
    input  fractal_sync_req_t wdata,
    output fractal_sync_req_t head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be a power of two and at least 2");
    end

    fractal_sync_req_t mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fractal_sync_node_ctrl.sv
// Request-side control in front of the fractal_sync back-routing RF: buffers
// requests per port, arbitrates same-index heads and registers responses.
module fractal_sync_node_ctrl
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned IDX_WIDTH  = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_PORTS-1:0]   req_valid_i,
    output logic [N_PORTS-1:0]   req_ready_o,
    input  logic [N_PORTS-1:0]   req_set_i,
    input  logic [IDX_WIDTH-1:0] req_idx_i [N_PORTS],
    input  logic [SD_WIDTH-1:0]  req_sd_i [N_PORTS],
    output logic [N_PORTS-1:0]   rsp_valid_o,
    input  logic [N_PORTS-1:0]   rsp_ready_i,
    output logic [IDX_WIDTH-1:0] rsp_idx_o [N_PORTS],
    output logic [SD_WIDTH-1:0]  rsp_sd_o [N_PORTS],
    output logic [N_PORTS-1:0]   rf_check_o,
    output logic [N_PORTS-1:0]   rf_set_o,
    output logic [SD_WIDTH-1:0]  rf_sd_o [N_PORTS],
    output logic [IDX_WIDTH-1:0] rf_idx_o [N_PORTS],
    output logic [N_PORTS-1:0]   rf_idx_valid_o,
    input  logic [N_PORTS-1:0]   rf_present_i,
    input  logic [SD_WIDTH-1:0]  rf_sd_i [N_PORTS]
);

    if ((2 ** IDX_WIDTH) < N_REGS) begin : g_bad_idx_width
        $fatal(1, "IDX_WIDTH too narrow to address N_REGS entries");
    end
    if (IDX_WIDTH != REQ_IDX_WIDTH) begin : g_bad_req_width
        $fatal(1, "IDX_WIDTH must match the request type index width");
    end

    fractal_sync_req_t    head [N_PORTS];
    logic [N_PORTS-1:0]   full;
    logic [N_PORTS-1:0]   empty;
    logic [N_PORTS-1:0]   conflict;
    logic [N_PORTS-1:0]   grant;

    // A non-empty lower port with the same head idx blocks, granted or not.
    always_comb begin
        conflict = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (!empty[q] && (head[q].idx == head[p].idx)) begin
                    conflict[p] = 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        fractal_sync_req_t        wdata;
        logic                     rsp_valid;
        logic [IDX_WIDTH-1:0]     rsp_idx;
        logic [SD_WIDTH-1:0]      rsp_sd;

        assign wdata = '{set: req_set_i[p], idx: req_idx_i[p], sd: req_sd_i[p]};

        fractal_sync_req_fifo #(
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .push  (req_valid_i[p]),
            .pop   (grant[p]),
            .wdata (wdata),
            .head  (head[p]),
            .full  (full[p]),
            .empty (empty[p])
        );

        assign grant[p] = !empty[p] && !conflict[p]
                          && (head[p].set || !rsp_valid || rsp_ready_i[p]);

        assign req_ready_o[p]    = !full[p];
        assign rf_idx_valid_o[p] = !empty[p];
        assign rf_idx_o[p]       = head[p].idx;
        assign rf_sd_o[p]        = head[p].sd;
        assign rf_check_o[p]     = grant[p] && !head[p].set;
        assign rf_set_o[p]       = grant[p] && head[p].set;

        // A completing check may refill the slot in the cycle it drains.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rsp_valid <= 1'b0;
                rsp_idx   <= '0;
                rsp_sd    <= '0;
            end else if (rf_check_o[p] && rf_present_i[p]) begin
                rsp_valid <= 1'b1;
                rsp_idx   <= head[p].idx;
                rsp_sd    <= rf_sd_i[p] | head[p].sd;
            end else if (rsp_ready_i[p]) begin
                rsp_valid <= 1'b0;
            end
        end

        assign rsp_valid_o[p] = rsp_valid;
        assign rsp_idx_o[p]   = rsp_idx;
        assign rsp_sd_o[p]    = rsp_sd;
    end

endmodule

// File: tb/tb_fractal_sync_node_ctrl.sv
// Bench for fractal_sync_node_ctrl: a toy RF answers the strobes, and a
// queue-based model of the node predicts every output each cycle.
module tb_fractal_sync_node_ctrl;

    localparam int NP    = 2;
    localparam int NREG  = 2;
    localparam int IW    = 1;
    localparam int SDW   = 2;
    localparam int DEPTH = 2;

    typedef struct {
        logic           set;
        logic [IW-1:0]  idx;
        logic [SDW-1:0] sd;
    } mreq_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   req_valid, req_ready, req_set;
    logic [IW-1:0]   req_idx [NP];
    logic [SDW-1:0]  req_sd [NP];
    logic [NP-1:0]   rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_idx [NP];
    logic [SDW-1:0]  rsp_sd [NP];
    logic [NP-1:0]   rf_check, rf_set, rf_idx_valid, rf_present;
    logic [SDW-1:0]  rf_sd_out [NP];
    logic [SDW-1:0]  rf_sd_in [NP];
    logic [IW-1:0]   rf_idx [NP];

    logic [NREG-1:0] rfv;
    logic [SDW-1:0]  rfsd [NREG];

    mreq_t           mq [NP][$];
    logic [NP-1:0]   m_rv;
    logic [IW-1:0]   m_idx [NP];
    logic [SDW-1:0]  m_sd [NP];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int chk_cnt [NP];
    int set_cnt [NP];
    int last_chk [NP];

    always #5 clk = ~clk;

    fractal_sync_node_ctrl #(
        .N_PORTS(NP), .N_REGS(NREG), .IDX_WIDTH(IW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_set_i     (req_set),
        .req_idx_i     (req_idx),
        .req_sd_i      (req_sd),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_idx_o     (rsp_idx),
        .rsp_sd_o      (rsp_sd),
        .rf_check_o    (rf_check),
        .rf_set_o      (rf_set),
        .rf_sd_o       (rf_sd_out),
        .rf_idx_o      (rf_idx),
        .rf_idx_valid_o(rf_idx_valid),
        .rf_present_i  (rf_present),
        .rf_sd_i       (rf_sd_in)
    );

    // Toy RF: a check on a free entry records it, a check on a held entry clears it.
    for (genvar g = 0; g < NP; g++) begin : g_rf
        assign rf_present[g] = rfv[rf_idx[g]];
        assign rf_sd_in[g]   = rfsd[rf_idx[g]];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfv <= '0;
            for (int i = 0; i < NREG; i++) rfsd[i] <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rf_check[p]) begin
                    if (rfv[rf_idx[p]]) begin
                        rfv[rf_idx[p]] <= 1'b0;
                    end else begin
                        rfv[rf_idx[p]]  <= 1'b1;
                        rfsd[rf_idx[p]] <= rf_sd_out[p];
                    end
                end else if (rf_set[p]) begin
                    rfv[rf_idx[p]]  <= 1'b1;
                    rfsd[rf_idx[p]] <= rf_sd_out[p];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            m_rv[p]  = 1'b0;
            m_idx[p] = '0;
            m_sd[p]  = '0;
        end
    endtask

    task automatic clear_counts();
        for (int p = 0; p < NP; p++) begin
            chk_cnt[p]  = 0;
            set_cnt[p]  = 0;
            last_chk[p] = -1;
        end
    endtask

    task automatic idle();
        req_valid = '0;
        req_set   = '0;
    endtask

    task automatic drive(input int p, input logic set, input logic [IW-1:0] idx, input logic [SDW-1:0] sd);
        req_valid[p] = 1'b1;
        req_set[p]   = set;
        req_idx[p]   = idx;
        req_sd[p]    = sd;
    endtask

    // One clock: compare at the falling edge, advance the model, settle after the rising edge.
    task automatic step();
        mreq_t         h;
        logic [NP-1:0] erdy, ne, g, ech, eset;
        logic          blocked;
        @(negedge clk);
        cyc++;
        for (int p = 0; p < NP; p++) begin
            erdy[p] = (mq[p].size() < DEPTH);
            ne[p]   = (mq[p].size() != 0);
        end
        for (int p = 0; p < NP; p++) begin
            g[p] = 1'b0; ech[p] = 1'b0; eset[p] = 1'b0;
            if (ne[p]) begin
                blocked = 1'b0;
                for (int q = 0; q < p; q++)
                    if (ne[q] && (mq[q][0].idx == mq[p][0].idx)) blocked = 1'b1;
                g[p]    = !blocked && (mq[p][0].set || !m_rv[p] || rsp_ready[p]);
                ech[p]  = g[p] && !mq[p][0].set;
                eset[p] = g[p] && mq[p][0].set;
            end
            check_eq($sformatf("req_ready[%0d]", p), 32'(req_ready[p]), 32'(erdy[p]));
            check_eq($sformatf("idx_valid[%0d]", p), 32'(rf_idx_valid[p]), 32'(ne[p]));
            check_eq($sformatf("rf_check[%0d]", p), 32'(rf_check[p]), 32'(ech[p]));
            check_eq($sformatf("rf_set[%0d]", p), 32'(rf_set[p]), 32'(eset[p]));
            check_eq($sformatf("rsp_valid[%0d]", p), 32'(rsp_valid[p]), 32'(m_rv[p]));
            if (ne[p]) begin
                check_eq($sformatf("rf_idx[%0d]", p), 32'(rf_idx[p]), 32'(mq[p][0].idx));
                check_eq($sformatf("rf_sd[%0d]", p), 32'(rf_sd_out[p]), 32'(mq[p][0].sd));
            end
            if (m_rv[p]) begin
                check_eq($sformatf("rsp_idx[%0d]", p), 32'(rsp_idx[p]), 32'(m_idx[p]));
                check_eq($sformatf("rsp_sd[%0d]", p), 32'(rsp_sd[p]), 32'(m_sd[p]));
            end
            if (rf_check[p]) begin
                chk_cnt[p]++;
                last_chk[p] = cyc;
            end
            if (rf_set[p]) set_cnt[p]++;
        end
        for (int p = 0; p < NP; p++) begin
            if (m_rv[p] && rsp_ready[p]) m_rv[p] = 1'b0;
            if (g[p]) begin
                h = mq[p].pop_front();
                if (!h.set && rfv[h.idx]) begin
                    m_rv[p]  = 1'b1;
                    m_idx[p] = h.idx;
                    m_sd[p]  = rfsd[h.idx] | h.sd;
                end
            end
            if (req_valid[p] && erdy[p]) begin
                h.set = req_set[p]; h.idx = req_idx[p]; h.sd = req_sd[p];
                mq[p].push_back(h);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rsp_ready = '0;
        for (int p = 0; p < NP; p++) begin
            req_idx[p] = '0;
            req_sd[p]  = '0;
        end
        model_clear();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("rst_ready[%0d]", p), 32'(req_ready[p]), 32'd1);
            check_eq($sformatf("rst_rsp_valid[%0d]", p), 32'(rsp_valid[p]), 32'd0);
            check_eq($sformatf("rst_rsp_idx[%0d]", p), 32'(rsp_idx[p]), 32'd0);
            check_eq($sformatf("rst_rsp_sd[%0d]", p), 32'(rsp_sd[p]), 32'd0);
            check_eq($sformatf("rst_strobes[%0d]", p),
                     32'({rf_check[p], rf_set[p], rf_idx_valid[p]}), 32'd0);
            check_eq($sformatf("rst_rf_idx[%0d]", p), 32'(rf_idx[p]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        steps(3);

        // Check pair completed three cycles apart.
        clear_counts();
        drive(0, 1'b0, 1'b1, 2'b01); step();
        idle(); steps(2);
        drive(1, 1'b0, 1'b1, 2'b10); step();
        idle(); steps(3);
        check_eq("pair_chk_cnt0", 32'(chk_cnt[0]), 32'd1);
        check_eq("pair_rsp_valid0", 32'(rsp_valid[0]), 32'd0);
        check_eq("pair_rsp_valid1", 32'(rsp_valid[1]), 32'd1);
        check_eq("pair_rsp_idx1", 32'(rsp_idx[1]), 32'd1);
        check_eq("pair_rsp_sd1", 32'(rsp_sd[1]), 32'd3);
        rsp_ready = '1; steps(2);

        // Same-index heads in the same cycle: port0 first, port1 the cycle after.
        clear_counts();
        drive(0, 1'b0, 1'b0, 2'b01);
        drive(1, 1'b0, 1'b0, 2'b10);
        step();
        idle(); steps(4);
        check_eq("conflict_order", 32'(last_chk[1] - last_chk[0]), 32'd1);
        check_eq("conflict_cnt1", 32'(chk_cnt[1]), 32'd1);

        // Two completing checks on port1 while its response is blocked.
        drive(0, 1'b0, 1'b0, 2'b01); step();
        drive(0, 1'b0, 1'b1, 2'b01); step();
        idle(); steps(3);
        clear_counts();
        rsp_ready = 2'b01;
        drive(1, 1'b0, 1'b0, 2'b10); step();
        drive(1, 1'b0, 1'b1, 2'b10); step();
        idle(); steps(4);
        check_eq("stall_chk_cnt1", 32'(chk_cnt[1]), 32'd1);
        rsp_ready = '1; steps(4);
        check_eq("release_chk_cnt1", 32'(chk_cnt[1]), 32'd2);

        // Fill port0 behind a held response, then drain and wrap.
        rsp_ready = '0;
        drive(1, 1'b0, 1'b0, 2'b10); step();
        idle(); steps(2);
        drive(0, 1'b0, 1'b0, 2'b01); step();
        idle(); steps(2);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 1'b1, 2'(i)); step();
        end
        check_eq("full_ready0", 32'(req_ready[0]), 32'd0);
        idle(); rsp_ready = 2'b01; step();
        check_eq("unfull_ready0", 32'(req_ready[0]), 32'd1);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(0, 1'(i % 3 == 0), 1'(i), 2'(i + 1)); step();
        end
        idle(); rsp_ready = '1; steps(6);

        // Set-only request: strobe without a response.
        clear_counts();
        drive(0, 1'b1, 1'b1, 2'b10); step();
        idle(); steps(3);
        check_eq("set_cnt0", 32'(set_cnt[0]), 32'd1);
        check_eq("set_chk_cnt0", 32'(chk_cnt[0]), 32'd0);
        check_eq("set_no_rsp0", 32'(rsp_valid[0]), 32'd0);

        // Asynchronous reset with requests and a response in flight.
        rsp_ready = '0;
        drive(0, 1'b0, 1'b0, 2'b01); drive(1, 1'b0, 1'b1, 2'b10); step();
        drive(1, 1'b0, 1'b1, 2'b01); drive(0, 1'b0, 1'b0, 2'b10); step();
        drive(0, 1'b0, 1'b1, 2'b11); step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("arst_rsp_valid[%0d]", p), 32'(rsp_valid[p]), 32'd0);
            check_eq($sformatf("arst_idx_valid[%0d]", p), 32'(rf_idx_valid[p]), 32'd0);
            check_eq($sformatf("arst_ready[%0d]", p), 32'(req_ready[p]), 32'd1);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        steps(2);

        // Randomized traffic with bursts of response back-pressure.
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++) begin
                req_valid[p] = 1'($urandom_range(0, 1));
                req_set[p]   = ($urandom_range(0, 3) == 0);
                req_idx[p]   = IW'($urandom());
                req_sd[p]    = SDW'($urandom());
                if ((c / 50) % 3 == 2) rsp_ready[p] = ($urandom_range(0, 7) == 0);
                else                   rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        idle(); rsp_ready = '1; steps(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
